// File: rtl/bpi_burst_seq_pkg.sv
// Shared types for the BPI burst sequencer: state encodings, strobe bundle,
// default timing constants and small helpers used by the FSM.
package bpi_burst_seq_pkg;

  localparam int DEF_RD_WAIT  = 3;
  localparam int DEF_WR_PULSE = 2;
  localparam int DEF_WR_RECOV = 1;

  typedef enum logic [3:0] {
    ST_STANDBY    = 4'h0,
    ST_CAPTURE    = 4'h1,
    ST_LATCH_ADDR = 4'h2,
    ST_RD_WAIT    = 4'h3,
    ST_LOAD       = 4'h4,
    ST_DBG_HOLD   = 4'h5,
    ST_WR_DATA    = 4'h6,
    ST_WR_PULSE   = 4'h7,
    ST_WR_RECOV   = 4'h8,
    ST_DONE       = 4'h9
  } state_t;

  typedef struct packed {
    logic busy;
    logic cap;
    logic e;
    logic g;
    logic l;
    logic w;
    logic load;
  } strobes_t;

  // Strobe levels owned by each state; outputs register this for the state being entered.
  function automatic strobes_t decode_strobes(input state_t st);
    strobes_t s;
    s      = '0;
    s.busy = (st != ST_STANDBY);
    s.cap  = (st == ST_CAPTURE);
    s.l    = (st == ST_LATCH_ADDR);
    s.e    = (st == ST_LATCH_ADDR) || (st == ST_RD_WAIT) || (st == ST_LOAD) ||
             (st == ST_DBG_HOLD) || (st == ST_WR_PULSE);
    s.g    = (st == ST_RD_WAIT) || (st == ST_LOAD) || (st == ST_DBG_HOLD);
    s.w    = (st == ST_WR_PULSE);
    s.load = (st == ST_LOAD);
    return s;
  endfunction

  // Timer preload for a state lasting 'cycles' cycles; counter exits on zero.
  function automatic logic [3:0] timer_preload(input int unsigned cycles);
    if (cycles == 0) return 4'd0;
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/bpi_burst_seq_if.sv
// Command/status and flash-strobe bundle between the BPI command logic
// (master) and the burst sequencer (slave).
interface bpi_burst_seq_if #(
  parameter int ADDR_W = 23,
  parameter int CNT_W  = 4
);
  logic              EXECUTE;
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDR_IN;
  logic [CNT_W-1:0]  LEN;
  logic              WR_VLD;
  logic              DEBUG;
  logic              GO;
  logic              ABORT;

  logic              BUSY;
  logic              CAP;
  logic              E;
  logic              G;
  logic              L;
  logic              W;
  logic              LOAD;
  logic              WR_ACK;
  logic              ERR;
  logic              DONE;
  logic [ADDR_W-1:0] ADDR_OUT;
  logic [CNT_W-1:0]  WORD_CNT;
  logic [3:0]        INTF_STATE;

  modport master (
    output EXECUTE, READ, WRITE, ADDR_IN, LEN, WR_VLD, DEBUG, GO, ABORT,
    input  BUSY, CAP, E, G, L, W, LOAD, WR_ACK, ERR, DONE,
           ADDR_OUT, WORD_CNT, INTF_STATE
  );

  modport slave (
    input  EXECUTE, READ, WRITE, ADDR_IN, LEN, WR_VLD, DEBUG, GO, ABORT,
    output BUSY, CAP, E, G, L, W, LOAD, WR_ACK, ERR, DONE,
           ADDR_OUT, WORD_CNT, INTF_STATE
  );
endinterface

// File: rtl/bpi_burst_seq_wait_timer.sv
// Loadable 4-bit down-counter with zero flag; times the read wait,
// write pulse and write recovery phases of the sequencer.
module bpi_burst_seq_wait_timer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  // Saturates at zero so the count can never wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/bpi_burst_seq.sv
// BPI parallel-flash burst sequencer: captures a start address and length,
// then runs auto-incrementing read or write word cycles on the flash strobes.
module bpi_burst_seq
  import bpi_burst_seq_pkg::*;
#(
  parameter int ADDR_W   = 23,
  parameter int CNT_W    = 4,
  parameter int RD_WAIT  = DEF_RD_WAIT,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int WR_RECOV = DEF_WR_RECOV
) (
  input logic CLK,
  input logic RST,
  bpi_burst_seq_if.slave bus
);

  state_t     state;
  state_t     next_state;
  strobes_t   next_strobes;
  logic       capture_en;
  logic       advance;
  logic       last_word;
  logic       err_pulse;
  logic       timer_load;
  logic [3:0] timer_val;
  logic       timer_zero;

  bpi_burst_seq_wait_timer u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (~timer_load),
    .zero     (timer_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_STANDBY;
    else     state <= next_state;
  end

  // Abort overrides every other exit; a finished word either advances or ends the burst.
  always_comb begin
    next_state = state;
    capture_en = 1'b0;
    advance    = 1'b0;
    err_pulse  = 1'b0;
    last_word  = (bus.WORD_CNT == '0);
    if ((state != ST_STANDBY) && bus.ABORT) begin
      next_state = ST_STANDBY;
    end else begin
      case (state)
        ST_STANDBY: begin
          if (bus.EXECUTE) begin
            next_state = ST_CAPTURE;
            capture_en = 1'b1;
          end
        end
        ST_CAPTURE: next_state = ST_LATCH_ADDR;
        ST_LATCH_ADDR: begin
          if (bus.READ && bus.WRITE) begin
            next_state = ST_STANDBY;
            err_pulse  = 1'b1;
          end else if (bus.WRITE) begin
            next_state = ST_WR_DATA;
          end else if (bus.READ) begin
            next_state = ST_RD_WAIT;
          end else begin
            next_state = ST_STANDBY;
          end
        end
        ST_RD_WAIT: begin
          if (timer_zero) next_state = ST_LOAD;
        end
        ST_LOAD: begin
          if (bus.DEBUG) begin
            next_state = ST_DBG_HOLD;
          end else begin
            advance    = ~last_word;
            next_state = last_word ? ST_DONE : ST_RD_WAIT;
          end
        end
        ST_DBG_HOLD: begin
          if (bus.GO) begin
            advance    = ~last_word;
            next_state = last_word ? ST_DONE : ST_RD_WAIT;
          end
        end
        ST_WR_DATA: begin
          if (bus.WR_VLD) next_state = ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (timer_zero) begin
            if (WR_RECOV == 0) begin
              advance    = ~last_word;
              next_state = last_word ? ST_DONE : ST_WR_DATA;
            end else begin
              next_state = ST_WR_RECOV;
            end
          end
        end
        ST_WR_RECOV: begin
          if (timer_zero) begin
            advance    = ~last_word;
            next_state = last_word ? ST_DONE : ST_WR_DATA;
          end
        end
        ST_DONE: next_state = ST_STANDBY;
        default: next_state = ST_STANDBY;
      endcase
    end
  end

  // Timer reloads on every state change so each timed phase starts fresh.
  always_comb begin
    timer_load = (next_state != state);
    timer_val  = 4'd0;
    case (next_state)
      ST_RD_WAIT:  timer_val = timer_preload(RD_WAIT);
      ST_WR_PULSE: timer_val = timer_preload(WR_PULSE);
      ST_WR_RECOV: timer_val = timer_preload(WR_RECOV);
      default:     timer_val = 4'd0;
    endcase
  end

  assign next_strobes = decode_strobes(next_state);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.ADDR_OUT <= '0;
      bus.WORD_CNT <= '0;
    end else if (capture_en) begin
      bus.ADDR_OUT <= bus.ADDR_IN;
      bus.WORD_CNT <= bus.LEN;
    end else if (advance) begin
      bus.ADDR_OUT <= bus.ADDR_OUT + ADDR_W'(1);
      bus.WORD_CNT <= bus.WORD_CNT - CNT_W'(1);
    end
  end

  // Outputs are registered copies of the decode for the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.BUSY   <= 1'b0;
      bus.CAP    <= 1'b0;
      bus.E      <= 1'b0;
      bus.G      <= 1'b0;
      bus.L      <= 1'b0;
      bus.W      <= 1'b0;
      bus.LOAD   <= 1'b0;
      bus.WR_ACK <= 1'b0;
      bus.ERR    <= 1'b0;
      bus.DONE   <= 1'b0;
    end else begin
      bus.BUSY   <= next_strobes.busy;
      bus.CAP    <= next_strobes.cap;
      bus.E      <= next_strobes.e;
      bus.G      <= next_strobes.g;
      bus.L      <= next_strobes.l;
      bus.W      <= next_strobes.w;
      bus.LOAD   <= next_strobes.load;
      bus.WR_ACK <= (next_state == ST_WR_PULSE) && (state != ST_WR_PULSE);
      bus.ERR    <= err_pulse;
      bus.DONE   <= (next_state == ST_DONE);
    end
  end

  assign bus.INTF_STATE = state;

endmodule

// File: tb/tb_bpi_burst_seq.sv
// Self-checking bench for bpi_burst_seq: each burst is expanded into an expected
// per-cycle bus trace from the protocol rules, then driven and compared cycle by cycle.
module tb_bpi_burst_seq;

  localparam int ADDR_W   = 23;
  localparam int CNT_W    = 4;
  localparam int RD_WAIT  = 3;
  localparam int WR_PULSE = 2;
  localparam int WR_RECOV = 1;

  typedef struct packed {
    logic [3:0]        st;
    logic              busy, cap, e, g, l, w, load, wr_ack, err, done;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
  } obs_t;

  typedef struct packed {
    logic              execute, read, write, wr_vld, debug, go, abort;
    logic [ADDR_W-1:0] addr_in;
    logic [CNT_W-1:0]  len;
  } drv_t;

  typedef struct packed {
    drv_t drv;
    obs_t exp;
  } step_t;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  step_t trace[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  logic  go_pending  = 1'b0;
  logic  vld_pending = 1'b0;

  always #5 CLK = ~CLK;

  bpi_burst_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  bpi_burst_seq #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_WAIT(RD_WAIT),
    .WR_PULSE(WR_PULSE), .WR_RECOV(WR_RECOV)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  function automatic obs_t expect_in(input int st, input logic [ADDR_W-1:0] a,
                                     input logic [CNT_W-1:0] c);
    obs_t o;
    o      = '0;
    o.st   = st[3:0];
    o.addr = a;
    o.cnt  = c;
    o.busy = (st != 0);
    o.cap  = (st == 1);
    o.l    = (st == 2);
    o.e    = st inside {2, 3, 4, 5, 7};
    o.g    = st inside {3, 4, 5};
    o.w    = (st == 7);
    o.load = (st == 4);
    o.done = (st == 9);
    return o;
  endfunction

  // Inputs that must be ignored mid-burst get scrambled.
  function automatic drv_t jitter(input drv_t d);
    drv_t r;
    r         = d;
    r.execute = 1'($urandom_range(0, 1));
    r.addr_in = ADDR_W'($urandom);
    r.len     = CNT_W'($urandom);
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st     = bus.INTF_STATE;
    o.busy   = bus.BUSY;
    o.cap    = bus.CAP;
    o.e      = bus.E;
    o.g      = bus.G;
    o.l      = bus.L;
    o.w      = bus.W;
    o.load   = bus.LOAD;
    o.wr_ack = bus.WR_ACK;
    o.err    = bus.ERR;
    o.done   = bus.DONE;
    o.addr   = bus.ADDR_OUT;
    o.cnt    = bus.WORD_CNT;
    return o;
  endfunction

  task automatic apply_stimulus(input drv_t d);
    bus.EXECUTE = d.execute;
    bus.READ    = d.read;
    bus.WRITE   = d.write;
    bus.WR_VLD  = d.wr_vld;
    bus.DEBUG   = d.debug;
    bus.GO      = d.go;
    bus.ABORT   = d.abort;
    bus.ADDR_IN = d.addr_in;
    bus.LEN     = d.len;
  endtask

  task automatic check_output(input string tag, input obs_t exp);
    obs_t got;
    got = sample();
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_step(input drv_t d, input obs_t o);
    step_t s;
    s.drv        = d;
    s.drv.go     = go_pending;
    s.drv.wr_vld = vld_pending;
    s.exp        = o;
    go_pending   = 1'b0;
    vld_pending  = 1'b0;
    trace.push_back(s);
  endtask

  // Expands one command into its expected cycle trace, ending with one idle Standby cycle.
  task automatic build_burst(input bit wr, input bit bad, input logic [CNT_W-1:0] len,
                             input logic [ADDR_W-1:0] addr, input bit dbg,
                             input int go_wait, input int vld_wait);
    drv_t                d;
    obs_t                o;
    logic [ADDR_W-1:0]   a;
    logic [CNT_W-1:0]    c;
    int                  vw;
    d         = '0;
    d.execute = 1'b1;
    d.addr_in = addr;
    d.len     = len;
    d.read    = bad || !wr;
    d.write   = bad || wr;
    d.debug   = dbg;
    push_step(d, expect_in(1, addr, len));
    push_step(jitter(d), expect_in(2, addr, len));
    if (bad) begin
      o     = expect_in(0, addr, len);
      o.err = 1'b1;
      push_step(jitter(d), o);
    end else begin
      for (int w = 0; w <= int'(len); w++) begin
        a = addr + ADDR_W'(w);
        c = len - CNT_W'(w);
        if (!wr) begin
          repeat (RD_WAIT) push_step(jitter(d), expect_in(3, a, c));
          push_step(jitter(d), expect_in(4, a, c));
          if (dbg) begin
            repeat (go_wait) push_step(jitter(d), expect_in(5, a, c));
            go_pending = 1'b1;
          end
        end else begin
          vw = (vld_wait >= 0) ? vld_wait : int'($urandom_range(0, 3));
          repeat (vw + 1) push_step(jitter(d), expect_in(6, a, c));
          vld_pending = 1'b1;
          o        = expect_in(7, a, c);
          o.wr_ack = 1'b1;
          push_step(jitter(d), o);
          repeat (WR_PULSE - 1) push_step(jitter(d), expect_in(7, a, c));
          repeat (WR_RECOV) push_step(jitter(d), expect_in(8, a, c));
        end
      end
      push_step(jitter(d), expect_in(9, addr + ADDR_W'(len), '0));
      push_step(jitter(d), expect_in(0, addr + ADDR_W'(len), '0));
    end
    o     = trace[$].exp;
    o.err = 1'b0;
    push_step('0, o);
  endtask

  // Abort is seen in the state of step idx-1; address and count hold their values.
  task automatic inject_abort(input int idx);
    step_t s;
    obs_t  prev;
    prev = trace[idx-1].exp;
    s    = trace[idx];
    while (trace.size() > idx) void'(trace.pop_back());
    s.drv.abort = 1'b1;
    s.exp       = expect_in(0, prev.addr, prev.cnt);
    trace.push_back(s);
    s.drv = '0;
    trace.push_back(s);
  endtask

  task automatic run_trace(input string name, input int stop_st);
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge CLK);
      apply_stimulus(trace[i].drv);
      @(posedge CLK);
      #1;
      check_output($sformatf("%s[%0d]", name, i), trace[i].exp);
      if (int'(trace[i].exp.st) == stop_st) break;
    end
    trace.delete();
  endtask

  initial begin
    int   hold_seen;
    int   abort_idx;
    bit   wr;
    logic [CNT_W-1:0]  len;
    logic [ADDR_W-1:0] addr;

    apply_stimulus('0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_output("reset_state", '0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_output("idle_after_reset", '0);

    $display("[TB] single-word read");
    build_burst(0, 0, 4'd0, 23'h000100, 0, 0, 0);
    run_trace("rd_single", -1);

    $display("[TB] read burst across address wrap");
    build_burst(0, 0, 4'd3, 23'h7FFFFE, 0, 0, 0);
    run_trace("rd_wrap", -1);

    $display("[TB] write burst with late data");
    build_burst(1, 0, 4'd1, 23'h012345, 0, 0, 5);
    run_trace("wr_late", -1);

    $display("[TB] illegal read+write command");
    build_burst(0, 1, 4'd2, 23'h003000, 0, 0, 0);
    run_trace("rd_wr_err", -1);

    $display("[TB] debug hold then release");
    build_burst(0, 0, 4'd1, 23'h044440, 1, 10, 0);
    run_trace("dbg_go", -1);

    $display("[TB] abort during debug hold");
    build_burst(0, 0, 4'd1, 23'h055550, 1, 10, 0);
    hold_seen = 0;
    abort_idx = 0;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i].exp.st == 4'h5) begin
        hold_seen++;
        if (hold_seen == 3) begin
          abort_idx = i + 1;
          break;
        end
      end
    end
    inject_abort(abort_idx);
    run_trace("dbg_abort", -1);

    $display("[TB] reset during write pulse");
    build_burst(1, 0, 4'd1, 23'h0ABCDE, 0, 0, 0);
    run_trace("rst_pre", 7);
    #2;
    RST = 1'b1;
    #1;
    check_output("rst_async", '0);
    @(posedge CLK);
    #1;
    check_output("rst_hold", '0);
    @(negedge CLK);
    RST = 1'b0;
    apply_stimulus('0);
    build_burst(0, 0, 4'd2, 23'h000010, 0, 0, 0);
    run_trace("after_rst", -1);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 14; n++) begin
      wr   = 1'($urandom_range(0, 1));
      len  = ($urandom_range(0, 5) == 0) ? 4'hF : CNT_W'($urandom_range(0, 4));
      addr = ($urandom_range(0, 2) == 0) ? (23'h7FFFFF - ADDR_W'($urandom_range(0, 3)))
                                         : ADDR_W'($urandom);
      build_burst(wr, ($urandom_range(0, 7) == 0), len, addr,
                  (!wr && ($urandom_range(0, 2) == 0)), int'($urandom_range(1, 4)), -1);
      if ($urandom_range(0, 3) == 0) inject_abort(int'($urandom_range(1, trace.size() - 3)));
      run_trace($sformatf("rnd%0d", n), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
